// File: rtl/multiply_sequencer.sv
// multiply_sequencer: iterative shift-add MUL/MLA with pipeline stall and NZCV update.
// Optional MUL_EARLY_TERM_EN ends the run as soon as the remaining multiplier bits are zero.
module multiply_sequencer #(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic             accumulate,
    input  logic [WIDTH-1:0] valRm,
    input  logic [WIDTH-1:0] valRs,
    input  logic [WIDTH-1:0] valRn,
    input  logic [3:0]       status,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       statusOut
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, stateNext;
    logic [WIDTH-1:0]   mcand, mplier, acc, accNext;
    logic [1:0]         cv;
    logic [COUNT_W-1:0] count;
    logic               lastIter;
    logic               unusedFlags;
    assign unusedFlags = ^status[3:2];
    always_comb begin
        accNext = mplier[0] ? acc + mcand : acc;
`ifdef MUL_EARLY_TERM_EN
        lastIter = (count == COUNT_W'(WIDTH - 1)) || ((mplier >> 1) == '0);
`else
        lastIter = count == COUNT_W'(WIDTH - 1);
`endif
        stateNext = flush ? IDLE :
                    state == IDLE ? (start ? RUN : IDLE) :
                    state == RUN  ? (lastIter ? DONE : RUN) : IDLE;
        busy  = state != IDLE;
        stall = (start & (state == IDLE)) | (state == RUN);
        done  = state == DONE;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cv        <= '0;
            count     <= '0;
            result    <= '0;
            statusOut <= '0;
        end else begin
            state <= stateNext;
            if (state == IDLE && start && !flush) begin
                mcand  <= valRm;
                mplier <= valRs;
                acc    <= accumulate ? valRn : '0;
                cv     <= status[1:0];
                count  <= '0;
            end else if (state == RUN && !flush) begin
                acc    <= accNext;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + COUNT_W'(1);
                // result/flags are published on the edge entering DONE
                if (lastIter) begin
                    result    <= accNext;
                    statusOut <= {accNext[WIDTH-1], accNext == '0, cv};
                end
            end
        end
    end
endmodule

// File: tb/tb_multiply_sequencer.sv
// tb_multiply_sequencer: directed plus randomized checks against an arithmetic reference model.
module tb_multiply_sequencer;
    localparam int WIDTH = 32;
    logic clk = 0, rst = 0, start = 0, flush = 0, accumulate = 0;
    logic [WIDTH-1:0] valRm = 0, valRs = 0, valRn = 0;
    logic [3:0] status = 0;
    logic busy, stall, done;
    logic [WIDTH-1:0] result;
    logic [3:0] statusOut;
    int checks = 0, errors = 0;

    multiply_sequencer #(.WIDTH(WIDTH), .COUNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .accumulate(accumulate),
        .valRm(valRm), .valRs(valRs), .valRn(valRn), .status(status),
        .busy(busy), .stall(stall), .done(done), .result(result), .statusOut(statusOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int expLatency(input logic [WIDTH-1:0] rs);
`ifdef MUL_EARLY_TERM_EN
        int h = 0;
        for (int i = 0; i < WIDTH; i++) if (rs[i]) h = i + 1;
        return h < 1 ? 1 : h;
`else
        return WIDTH;
`endif
    endfunction

    // Caller must be at a negedge; drives the request immediately.
    task automatic runOp(input string tag, input logic [WIDTH-1:0] rm, rs, rn,
                         input logic accum, input logic [3:0] st);
        logic [WIDTH-1:0] expRes;
        logic [3:0] expStat;
        int cyc;
        logic stallOk, busyOk;
        expRes  = rm * rs + (accum ? rn : '0);
        expStat = {expRes[WIDTH-1], expRes == '0, st[1:0]};
        start = 1; valRm = rm; valRs = rs; valRn = rn; accumulate = accum; status = st;
        #1 check({tag, ".stallAccept"}, stall, 1);
        @(negedge clk);
        start = 0; valRm = $urandom; valRs = $urandom; valRn = $urandom;
        accumulate = $urandom; status = $urandom;
        cyc = 0; stallOk = 1; busyOk = 1;
        while (done !== 1'b1 && cyc <= WIDTH + 2) begin
            if (stall !== 1'b1) stallOk = 0;
            if (busy !== 1'b1) busyOk = 0;
            @(negedge clk);
            cyc++;
        end
        check({tag, ".doneCycle"}, cyc, expLatency(rs));
        check({tag, ".stallRun"}, stallOk, 1);
        check({tag, ".busyRun"}, busyOk, 1);
        check({tag, ".stallDone"}, stall, 0);
        check({tag, ".result"}, result, expRes);
        check({tag, ".statusOut"}, statusOut, expStat);
        @(negedge clk);
        check({tag, ".idleBusy"}, busy, 0);
        check({tag, ".idleDone"}, done, 0);
    endtask

    initial begin
        logic [WIDTH-1:0] prevRes, rs;
        logic [3:0] prevStat;
        logic sawDone;
        // reset held with start asserted
        start = 1; valRm = 9; valRs = 9;
        repeat (2) begin
            @(negedge clk);
            check("rst.busy", busy, 0);
            check("rst.done", done, 0);
            check("rst.result", result, 0);
            check("rst.statusOut", statusOut, 0);
        end
        start = 0; rst = 1;
        @(negedge clk);
        check("rst.noAccept", busy, 0);

        runOp("mul", 7, 6, 0, 0, 4'b0011);
        runOp("mlaWrap", 32'hFFFFFFFF, 2, 3, 1, 4'b1100);
        runOp("zero", 0, 5, 0, 0, 4'b0000);
        runOp("neg", 32'h80000000, 1, 0, 0, 4'b0010);
        runOp("early5", 11, 5, 4, 1, 4'b0001);
        runOp("rsZero", 123, 0, 77, 1, 4'b0101);

        // flush and start together in IDLE: flush wins
        start = 1; flush = 1; valRs = 3;
        @(negedge clk);
        start = 0; flush = 0;
        check("flushStart.busy", busy, 0);

        // flush mid-run with an ignored second start
        prevRes = result; prevStat = statusOut;
        start = 1; valRm = 3; valRs = 32'hFFFFFFFF; valRn = 0; accumulate = 0; status = 4'b0011;
        @(negedge clk);
        start = 0; sawDone = 0;
        for (int c = 0; c <= 10; c++) begin
            if (done === 1'b1) sawDone = 1;
            start = (c == 5); flush = (c == 10);
            if (c == 5) valRs = 1;
            @(negedge clk);
        end
        start = 0; flush = 0;
        check("flush.busy", busy, 0);
        check("flush.noDone", sawDone | done, 0);
        check("flush.result", result, prevRes);
        check("flush.statusOut", statusOut, prevStat);
        runOp("afterFlush", 13, 17, 5, 1, 4'b0010);

        // reset mid-operation abandons and clears
        start = 1; valRm = 5; valRs = 32'h80000001;
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        rst = 1;
        check("midRst.busy", busy, 0);
        check("midRst.result", result, 0);
        check("midRst.statusOut", statusOut, 0);

        for (int i = 0; i < 20; i++) begin
            rs = $urandom;
            if (i % 3 == 0) rs = rs >> $urandom_range(0, 31);
            runOp("rand", $urandom, rs, $urandom, 1'($urandom), 4'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multiply_sequencer.md
# multiply_sequencer

Iterative shift-add multiply/multiply-accumulate sequencer beside the execution stage. Runs ARM MUL/MLA over multiple cycles and stalls the pipeline until the product is ready. Returns the low `WIDTH` bits of the result and updated NZCV flags in the same `{N,Z,C,V}` order the ALU uses, with carry at bit 1.

## Interface
- `WIDTH`, 32, operand/result width.
- `COUNT_W`, 6, iteration counter width; must satisfy 2^COUNT_W > WIDTH.

- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-low reset.
- `start`  input  1  request; accepted only in IDLE.
- `flush`  input  1  synchronous abort.
- `accumulate`  input  1  1 = MLA (add `valRn`), 0 = MUL.
- `valRm`  input  WIDTH  multiplicand.
- `valRs`  input  WIDTH  multiplier.
- `valRn`  input  WIDTH  accumulate addend.
- `status`  input  4  current flags `{N,Z,C,V}`.
- `busy`  output  1  state != IDLE.
- `stall`  output  1  pipeline hold.
- `done`  output  1  one-cycle completion pulse.
- `result`  output  WIDTH  product; holds until the next `done`.
- `statusOut`  output  4  flags for the last completed operation.

## Operation
- States are IDLE, RUN and DONE. Each state and its exits:
  - **IDLE.** `start=1` and `flush=0` capture the operands:
    - `mcand <= valRm`, `mplier <= valRs`.
    - `acc <= accumulate ? valRn : 0`.
    - `cv <= status[1:0]`, `count <= 0`.
    - Next state is RUN.
  - **RUN.** One iteration per edge:
    - If `mplier[0]`: `acc <= acc + mcand`, modulo 2^WIDTH.
    - `mcand <= mcand << 1`, `mplier <= mplier >> 1`, `count <= count + 1`.
    - Exits to DONE when the iteration just performed has `count == WIDTH-1`.
  - **DONE.**
    - `done=1`; `result` and `statusOut` are already updated.
    - Next state is IDLE unconditionally.
- Result and flag rules:
  - `result <= acc_next` on the edge entering DONE.
  - On that same edge `statusOut <= {acc_next[WIDTH-1], acc_next==0, cv}`.
  - C and V pass through unchanged.
  - No overflow detection; the result is the low WIDTH bits.
- Output signals:
  - `stall = start & (state==IDLE) | (state==RUN)`. It is combinational, so the requesting instruction is held from its first cycle.
  - `stall=0` in DONE, so the pipeline advances and samples `result`.
- Boundary conditions:
  - `start` in RUN or DONE: ignored, no queuing.
  - `flush` in any state: next state IDLE, no `done`; `result`/`statusOut` unchanged.
  - `flush` and `start` together in IDLE: flush wins, start dropped.
  - Operand inputs are don't-care after the accept edge.
  - `rst=0` mid-operation: the operation is abandoned on the next edge, exactly like reset.
- Reset values: state IDLE, `busy=0`, `done=0`, `result=0`, `statusOut=0`, internal registers 0.

## Timing
- Edge 0 is the edge sampling an accepted `start`. Cycle n is the period after edge n.
- RUN lasts cycles 0..WIDTH-1, with iterations at edges 1..WIDTH.
- DONE, with `done=1`, occurs in cycle WIDTH (32 by default). The block is IDLE in cycle WIDTH+1.
- Earliest next accept is at edge WIDTH+1.
- `busy` is high in cycles 0..WIDTH.
- `stall` is high in the accept cycle and cycles 0..WIDTH-1.

## Configuration
- `MUL_EARLY_TERM_EN` defined:
  - RUN also exits to DONE when the shifted multiplier (`mplier >> 1`) is zero after the current iteration.
  - `done` arrives in cycle max(1, index of highest set bit of `valRs` + 1).
  - Multiplier 0 gives `done` in cycle 1, result = accumulate ? `valRn` : 0.
- Not defined: fixed latency, with `done` always in cycle WIDTH.
- Result and flags are identical either way.

## Test plan
- **Reset.** Hold `rst=0` for 2 cycles with `start=1`:
  - `busy=0`, `done=0`, `result=0`, `statusOut=0`.
  - No start is accepted while reset is low.
- **MUL.** `valRm=7`, `valRs=6`, `accumulate=0`, `status=4'b0011`:
  - `done` in cycle 32.
  - `result=42`, `statusOut=4'b0011`.
  - `stall` high from the accept cycle through cycle 31, low in cycle 32.
- **MLA wrap.** `valRm=32'hFFFFFFFF`, `valRs=2`, `valRn=3`, `accumulate=1`:
  - `result=32'h00000001`, `statusOut[3:2]=2'b00`.
- **Zero/negative flags.**
  - `valRm=0`, `valRs=5`: `result=0`, Z=1.
  - `valRm=32'h80000000`, `valRs=1`: N=1.
- **Early termination.** `valRs=5`:
  - With `MUL_EARLY_TERM_EN`, `done` in cycle 3.
  - Without it, `done` in cycle 32.
  - Both give the same result.
- **Flush and ignored start.**
  - Pulse `start` again in cycle 5 and `flush` in cycle 10.
  - Second start ignored; `busy=0` in cycle 11; no `done`; `result` keeps its previous value.
  - A new start in cycle 11 is accepted normally.
